// File: rtl/mem_access_arbiter.sv
// Core/host memory arbiter: registered grant FSM with alternating tie-break,
// key-denial counting and a timed lockout during which only the host is served.
module mem_access_arbiter #(
    parameter int unsigned LOCK_THRESH = 3,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [4:0]  core_addr,
    input  logic [31:0] core_wdata,
    input  logic        core_key_ok,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [4:0]  host_addr,
    input  logic [31:0] host_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_wenable,
    output logic        mem_renable,
    output logic [4:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_gnt,
    output logic        host_gnt,
    output logic        core_rvalid,
    output logic        host_rvalid,
    output logic [31:0] rdata,
    output logic        core_stall,
    output logic        violation,
    output logic        lockout
);

    typedef enum logic [1:0] {IDLE, GNT_CORE, GNT_HOST, LOCK} state_t;

    state_t      r_state;
    logic        r_last_host;
    logic        r_lock_hgnt;
    logic        r_core_rvalid;
    logic        r_host_rvalid;
    logic        r_violation;
    logic [2:0]  r_deny_cnt;
    logic [7:0]  r_lock_timer;
    logic [31:0] r_rdata;

    logic        w_core_pend;
    logic        w_host_pend;
    logic        w_eval;
    logic        w_deny;
    logic        w_pick_core;
    logic        w_pick_host;
    logic        w_lock_trip;
    logic [2:0]  w_deny_inc;

    assign core_gnt    = (r_state == GNT_CORE);
    assign host_gnt    = (r_state == GNT_HOST) | r_lock_hgnt;
    assign lockout     = (r_state == LOCK);
    assign core_stall  = core_req & ~core_gnt;
    assign core_rvalid = r_core_rvalid;
    assign host_rvalid = r_host_rvalid;
    assign violation   = r_violation;
    assign rdata       = r_rdata;

    // A req seen in its own grant cycle is the request being served, not a new one.
    always_comb begin
        w_core_pend = core_req & ~core_gnt;
        w_host_pend = host_req & ~host_gnt;
        w_eval      = (r_state != LOCK);
        w_deny      = w_eval & w_core_pend & ~core_key_ok;
        w_deny_inc  = (r_deny_cnt == 3'd7) ? 3'd7 : r_deny_cnt + 3'd1;
        w_lock_trip = w_deny & (32'(w_deny_inc) >= LOCK_THRESH);
        w_pick_core = w_eval & w_core_pend & core_key_ok & (~w_host_pend | r_last_host);
        w_pick_host = w_eval & w_host_pend & ~w_pick_core;
    end

    always_comb begin
        mem_wenable = 1'b0;
        mem_renable = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (core_gnt) begin
            mem_wenable = core_we;
            mem_renable = ~core_we;
            mem_addr    = core_addr;
            mem_wdata   = core_wdata;
        end else if (host_gnt) begin
            mem_wenable = host_we;
            mem_renable = ~host_we;
            mem_addr    = host_addr;
            mem_wdata   = host_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_last_host   <= 1'b1;
            r_lock_hgnt   <= 1'b0;
            r_core_rvalid <= 1'b0;
            r_host_rvalid <= 1'b0;
            r_violation   <= 1'b0;
            r_deny_cnt    <= '0;
            r_lock_timer  <= '0;
            r_rdata       <= '0;
        end else begin
            r_violation   <= w_deny;
            r_core_rvalid <= core_gnt & ~core_we;
            r_host_rvalid <= host_gnt & ~host_we;
            r_lock_hgnt   <= 1'b0;
            if (mem_renable) begin
                r_rdata <= mem_rdata;
            end
            case (r_state)
                LOCK: begin
                    // Host grants inside LOCK only while at least one more lock cycle remains.
                    if (r_lock_timer == 8'd0) begin
                        r_state <= IDLE;
                    end else begin
                        r_lock_timer <= r_lock_timer - 8'd1;
                        if (w_host_pend) begin
                            r_lock_hgnt <= 1'b1;
                            r_last_host <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (w_lock_trip) begin
                        r_state      <= LOCK;
                        r_lock_timer <= 8'(LOCK_CYCLES - 1);
                        r_deny_cnt   <= '0;
                    end else begin
                        if (w_deny) begin
                            r_deny_cnt <= w_deny_inc;
                        end
                        if (w_pick_core) begin
                            r_state     <= GNT_CORE;
                            r_last_host <= 1'b0;
                        end else if (w_pick_host) begin
                            r_state     <= GNT_HOST;
                            r_last_host <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench: cycle-level behavioural model of the arbiter, directed
// scenarios with literal expectations, then a randomized protocol-respecting run.
module tb_mem_access_arbiter;

    localparam int TH  = 3;
    localparam int CYC = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, core_key_ok, host_req, host_we;
    logic [4:0]  core_addr, host_addr;
    logic [31:0] core_wdata, host_wdata, mem_rdata;
    logic        mem_wenable, mem_renable, core_gnt, host_gnt;
    logic        core_rvalid, host_rvalid, core_stall, violation, lockout;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata, rdata;

    int checks   = 0;
    int failures = 0;

    // Model state: expected registered outputs for the current cycle.
    bit          m_gc, m_gh, m_rvc, m_rvh, m_viol, m_gc_prev, m_gh_prev, m_last_core;
    logic [31:0] m_rdata;
    int          m_lock_left, m_denies;
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;

    mem_access_arbiter #(.LOCK_THRESH(TH), .LOCK_CYCLES(CYC)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_key_ok(core_key_ok),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .mem_rdata(mem_rdata),
        .mem_wenable(mem_wenable), .mem_renable(mem_renable),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_gnt(core_gnt), .host_gnt(host_gnt),
        .core_rvalid(core_rvalid), .host_rvalid(host_rvalid),
        .rdata(rdata), .core_stall(core_stall),
        .violation(violation), .lockout(lockout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across one rising edge using the inputs the DUT samples there.
    task automatic model_step();
        bit gc, gh, cp, hp, want_c;
        gc = m_gc;
        gh = m_gh;
        m_gc_prev = gc;
        m_gh_prev = gh;
        if (!reset) begin
            m_gc = 0; m_gh = 0; m_rvc = 0; m_rvh = 0; m_viol = 0;
            m_rdata = '0; m_lock_left = 0; m_denies = 0; m_last_core = 0;
            return;
        end
        m_rvc = gc && !core_we;
        m_rvh = gh && !host_we;
        if ((gc && !core_we) || (gh && !host_we)) m_rdata = mem_rdata;
        cp = core_req && !gc;
        hp = host_req && !gh;
        m_viol = 0; m_gc = 0; m_gh = 0;
        if (m_lock_left > 0) begin
            m_lock_left--;
            if (hp && m_lock_left > 0) begin
                m_gh = 1;
                m_last_core = 0;
            end
        end else begin
            if (cp && !core_key_ok) begin
                m_viol = 1;
                m_denies = (m_denies < 7) ? m_denies + 1 : 7;
                if (m_denies >= TH) begin
                    m_lock_left = CYC;
                    m_denies = 0;
                end
            end
            if (m_lock_left == 0) begin
                want_c = cp && core_key_ok;
                if (want_c && hp) begin
                    if (m_last_core) m_gh = 1; else m_gc = 1;
                end else begin
                    m_gc = want_c;
                    m_gh = hp;
                end
                if (m_gc) m_last_core = 1;
                if (m_gh) m_last_core = 0;
            end
        end
    endtask

    always @(negedge clk) begin : compare
        bit          ew, er;
        logic [4:0]  ea;
        logic [31:0] ed;
        if (chk_en) begin
            ew = 0; er = 0; ea = '0; ed = '0;
            if (m_gc) begin
                ew = core_we; er = !core_we; ea = core_addr; ed = core_wdata;
            end else if (m_gh) begin
                ew = host_we; er = !host_we; ea = host_addr; ed = host_wdata;
            end
            chk("core_gnt",    32'(core_gnt),    32'(m_gc));
            chk("host_gnt",    32'(host_gnt),    32'(m_gh));
            chk("mem_wenable", 32'(mem_wenable), 32'(ew));
            chk("mem_renable", 32'(mem_renable), 32'(er));
            chk("mem_addr",    32'(mem_addr),    32'(ea));
            chk("mem_wdata",   mem_wdata,        ed);
            chk("core_rvalid", 32'(core_rvalid), 32'(m_rvc));
            chk("host_rvalid", 32'(host_rvalid), 32'(m_rvh));
            chk("rdata",       rdata,            m_rdata);
            chk("core_stall",  32'(core_stall),  32'(core_req && !m_gc));
            chk("violation",   32'(violation),   32'(m_viol));
            chk("lockout",     32'(lockout),     32'(m_lock_left > 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0; core_key_ok = 1;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 0;
        idle_inputs();
        tick();
        tick();
        chk_en = 1;
        reset = 1;
    endtask

    task automatic drive_random();
        reset = ($urandom_range(0, 599) != 0);
        if (!core_req || m_gc_prev) begin
            core_req = ($urandom_range(0, 99) < 60);
            core_we = 1'($urandom_range(0, 1));
            core_addr = 5'($urandom);
            core_wdata = $urandom;
        end
        if (!host_req || m_gh_prev) begin
            host_req = ($urandom_range(0, 99) < 55);
            host_we = 1'($urandom_range(0, 1));
            host_addr = 5'($urandom);
            host_wdata = $urandom;
        end
        core_key_ok = ($urandom_range(0, 99) < 85);
        mem_rdata = $urandom;
    endtask

    initial begin
        int nviol, nlock, first_cg, nhg;
        idle_inputs();
        do_reset();
        @(negedge clk);
        chk("reset_core_gnt", 32'(core_gnt), 32'd0);
        chk("reset_lockout",  32'(lockout),  32'd0);
        chk("reset_rdata",    rdata,         32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);

        // Core read of address 5.
        core_req = 1; core_we = 0; core_addr = 5'd5; core_key_ok = 1;
        tick();
        mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("rd_core_gnt",    32'(core_gnt),    32'd1);
        chk("rd_mem_renable", 32'(mem_renable), 32'd1);
        chk("rd_mem_addr",    32'(mem_addr),    32'd5);
        chk("rd_model_gnt",   32'(m_gc),        32'd1);
        tick();
        core_req = 0; mem_rdata = '0;
        @(negedge clk);
        chk("rd_core_rvalid", 32'(core_rvalid), 32'd1);
        chk("rd_rdata",       rdata,            32'hDEADBEEF);

        // Both requesting continuously: grants alternate starting with core.
        do_reset();
        core_req = 1; core_addr = 5'd1; host_req = 1; host_addr = 5'd2;
        for (int k = 1; k <= 4; k++) begin
            tick();
            @(negedge clk);
            chk("alt_core_gnt", 32'(core_gnt), 32'(k % 2));
            chk("alt_host_gnt", 32'(host_gnt), 32'((k + 1) % 2));
        end

        // Three key denials -> lockout, host write served inside lockout.
        do_reset();
        core_req = 1; core_we = 1; core_addr = 5'd7; core_wdata = 32'hA5A5A5A5; core_key_ok = 0;
        nviol = 0; nlock = 0; first_cg = -1; nhg = 0;
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (k == 5) begin
                host_req = 1; host_we = 1; host_addr = 5'd9; host_wdata = 32'h12345678;
            end
            if (k == 7) host_req = 0;
            if (k == 10) core_key_ok = 1;
            if (k == 21) core_req = 0;
            @(negedge clk);
            nviol += int'(violation);
            nlock += int'(lockout);
            nhg += int'(host_gnt);
            if (core_gnt && first_cg < 0) first_cg = k;
            if (k == 3) chk("lock_start", 32'(lockout), 32'd1);
            if (k == 19) chk("lock_end", 32'(lockout), 32'd0);
            if (k == 6) begin
                chk("lk_host_gnt",    32'(host_gnt),    32'd1);
                chk("lk_mem_wenable", 32'(mem_wenable), 32'd1);
                chk("lk_mem_renable", 32'(mem_renable), 32'd0);
                chk("lk_mem_addr",    32'(mem_addr),    32'd9);
                chk("lk_mem_wdata",   mem_wdata,        32'h12345678);
                chk("lk_core_stall",  32'(core_stall),  32'd1);
            end
        end
        chk("lock_violations", 32'(nviol),    32'd3);
        chk("lock_cycles",     32'(nlock),    32'd16);
        chk("lock_first_cgnt", 32'(first_cg), 32'd20);
        chk("lock_host_gnts",  32'(nhg),      32'd1);

        // Reset asserted during the grant cycle of a core read.
        do_reset();
        core_req = 1; core_we = 0; core_addr = 5'd3; core_key_ok = 1; mem_rdata = 32'hCAFEF00D;
        tick();
        reset = 0;
        @(negedge clk);
        chk("rst_grant_cycle", 32'(core_gnt), 32'd1);
        tick();
        core_req = 0;
        @(negedge clk);
        chk("rst_core_rvalid", 32'(core_rvalid), 32'd0);
        chk("rst_core_gnt",    32'(core_gnt),    32'd0);
        chk("rst_mem_renable", 32'(mem_renable), 32'd0);
        chk("rst_rdata",       rdata,            32'd0);
        tick();
        reset = 1;

        // Randomized run, requesters hold each request until granted.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            tick();
            drive_random();
        end
        tick();
        reset = 1;
        idle_inputs();
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_arbiter.md
MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

Interface
REQ-001 Parameter: LOCK_THRESH, default 3, number of key-denied core accesses (1..7) that triggers lockout.
REQ-002 Parameter: LOCK_CYCLES, default 16, lockout duration in clock cycles (1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 core_req / core_we  input  1 / 1  core memory request; write when core_we=1, else read.
REQ-006 core_addr / core_wdata  input  5 / 32  core word address and write data.
REQ-007 core_key_ok  input  1  security key-access qualifier for the core request.
REQ-008 host_req / host_we  input  1 / 1  external host request; write when host_we=1.
REQ-009 host_addr / host_wdata  input  5 / 32  host word address and write data.
REQ-010 mem_rdata  input  32  memory read data, valid combinationally in the cycle renable is high.
REQ-011 mem_wenable / mem_renable  output  1 / 1  memory write and read strobes.
REQ-012 mem_addr / mem_wdata  output  5 / 32  memory address and write data.
REQ-013 core_gnt / host_gnt  output  1 / 1  one-cycle grant pulses.
REQ-014 core_rvalid / host_rvalid  output  1 / 1  one-cycle read-data-valid pulses.
REQ-015 rdata  output  32  registered read data.
REQ-016 core_stall  output  1  core_req high and no core grant in this cycle.
REQ-017 violation / lockout  output  1 / 1  key-denial pulse; lockout active level.

Function
REQ-018 FSM states SHALL be IDLE, GNT_CORE, GNT_HOST, LOCK; state registered, grants decoded from state.
REQ-019 Arbitration SHALL be evaluated in IDLE, GNT_CORE and GNT_HOST; next state GNT_CORE or GNT_HOST per REQ-020, else IDLE.
REQ-020 Both requesting: grant the one not granted last (last_grant bit, reset to HOST so core wins first tie); single requester wins outright.
REQ-021 Core request with core_key_ok=0 at evaluation SHALL NOT be granted; violation pulses next cycle, deny counter (3-bit, saturating) increments; host may be granted that same evaluation.
REQ-022 Deny counter reaching LOCK_THRESH SHALL force next state LOCK (overriding any grant), counter cleared.
REQ-023 LOCK: lockout=1, core never granted, host requests granted via GNT_HOST-equivalent strobes within LOCK, lock timer counts LOCK_CYCLES then returns to IDLE.
REQ-024 Grant cycle: exactly one of core_gnt/host_gnt =1, mem strobes/addr/wdata driven from that requester's inputs in the same cycle; mem_wenable and mem_renable never both 1.
REQ-025 Reads: rdata captures mem_rdata at end of grant cycle; matching rvalid pulses exactly one cycle later (latency request-to-rvalid = 2 cycles minimum).
REQ-026 Requester SHALL hold req/we/addr/wdata stable until its gnt; a req still high in the cycle after gnt is a new request.
REQ-027 Back-to-back grants permitted with no idle cycle; maximum wait for either requester is one grant of the other (outside LOCK).
REQ-028 All mem strobes, gnt and rvalid SHALL be 0 in IDLE and in LOCK cycles without a host grant.
REQ-029 core_stall SHALL be combinational: core_req & ~core_gnt; high throughout LOCK while core_req=1.

Reset
REQ-030 reset=0 at a clock edge: state IDLE, last_grant=HOST, deny counter 0, lock timer 0, rdata 0, all outputs 0 except core_stall which follows REQ-029.
REQ-031 Reset mid-grant or mid-lock SHALL abort the access: no rvalid emitted after reset, lockout drops the cycle after reset asserts.

Verification
REQ-032 Core read addr 5, key_ok=1, mem_rdata=0xDEADBEEF -> core_gnt, mem_renable, mem_addr=5 at cycle+1; core_rvalid, rdata=0xDEADBEEF at cycle+2.
REQ-033 core_req and host_req held high together from reset -> grants alternate CORE, HOST, CORE, HOST on consecutive cycles.
REQ-034 Three core requests with key_ok=0 (LOCK_THRESH=3) -> three violation pulses, no core_gnt, lockout=1 for exactly 16 cycles, core granted on first evaluation after.
REQ-035 Host write addr 9 data 0x12345678 during LOCK -> host_gnt, mem_wenable=1, mem_addr=9, mem_wdata=0x12345678; core still stalled.
REQ-036 reset=0 asserted in the grant cycle of a core read -> no core_rvalid, all outputs 0 next cycle, state IDLE.
